// File: rtl/tiny_eth_pkg.sv
// Shared types and constants for the tiny_eth serial receive path.
package tiny_eth_pkg;

    // Receive FSM: hunting for preamble+SFD, or assembling data words.
    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    // Start-of-frame delimiter as seen in the LSB-first shift window.
    localparam logic [7:0] ETH_SFD      = 8'hD5;
    // Preamble byte value; only the bit count is used for lock.
    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    // Width of the saturating hunt counter.
    localparam int         HUNT_CNT_W   = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HUNT_CNT_W-1:0] sat_inc(input logic [HUNT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tiny_eth_sfd_det.sv
// SFD detector: 8-bit LSB-first window plus saturating count of bits seen
// while the carrier is up. lock_o is combinational and reflects the value
// the window and counter take on the current edge, so the FSM can leave
// HUNT on the same edge that samples the last SFD bit.
module tiny_eth_sfd_det
    import tiny_eth_pkg::*;
(
    input  logic       rx_clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       serial_dv,
    input  logic       clr,
    input  logic [7:0] min_pre,
    output logic       lock_o
);

    logic [7:0]            win;
    logic [7:0]            win_next;
    logic [HUNT_CNT_W-1:0] hunt_cnt;
    logic [HUNT_CNT_W-1:0] cnt_next;
    logic [8:0]            cnt_need;

    assign win_next = {serial_in, win[7:1]};
    assign cnt_next = sat_inc(hunt_cnt);
    // SFD bits are counted too, so the threshold is preamble plus 8.
    assign cnt_need = {1'b0, min_pre} + 9'd8;
    assign lock_o   = serial_dv && (win_next == ETH_SFD) && ({1'b0, cnt_next} >= cnt_need);

    // Window and hunt counter advance on qualified bits, clear on carrier loss or request.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            win      <= '0;
            hunt_cnt <= '0;
        end else if (clr || !serial_dv) begin
            win      <= '0;
            hunt_cnt <= '0;
        end else begin
            win      <= win_next;
            hunt_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/tiny_eth_phy_rx.sv
// tiny_eth serial receive front-end: hunts for preamble+SFD, then packs
// LSB-first bits into DATA_W-bit words with valid/sof/eof/err strobes.
// Optional frame/error statistics counters are built when the macro
// TINY_ETH_PHY_RX_STATS_EN is defined.
// Handshake: rx_valid is a one-cycle strobe with no backpressure; the
// consumer must take rx_data (and rx_sof) in the cycle rx_valid is high.
module tiny_eth_phy_rx
    import tiny_eth_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int MIN_PRE_BITS = 16
) (
    input  logic              rx_clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              serial_dv,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_sof,
    output logic              rx_eof,
`ifdef TINY_ETH_PHY_RX_STATS_EN
    output logic              rx_err,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`else
    output logic              rx_err
`endif
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [7:0]        MIN_PRE  = 8'(MIN_PRE_BITS);

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   word_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic                first_word;
    logic                lock;
    logic                det_clr;

    // New bit enters at the MSB; written as shifts so DATA_W=1 stays legal.
    assign word_next = (shreg >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
    // Detector is held clear while in DATA and on the locking edge itself.
    assign det_clr   = (state == DATA) || lock;

    tiny_eth_sfd_det u_sfd_det (
        .rx_clk    (rx_clk),
        .rst       (rst),
        .serial_in (serial_in),
        .serial_dv (serial_dv),
        .clr       (det_clr),
        .min_pre   (MIN_PRE),
        .lock_o    (lock)
    );

    // Receive FSM with word assembly and registered one-cycle strobes.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            shreg      <= '0;
            bit_cnt    <= '0;
            first_word <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (lock) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        shreg      <= '0;
                        first_word <= 1'b1;
                    end
                end
                DATA: begin
                    if (serial_dv) begin
                        shreg <= word_next;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data    <= word_next;
                            rx_valid   <= 1'b1;
                            rx_sof     <= first_word;
                            first_word <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        // Carrier dropped: close the frame, a partial or empty frame is an error.
                        rx_eof     <= 1'b1;
                        rx_err     <= (bit_cnt != '0) || first_word;
                        bit_cnt    <= '0;
                        first_word <= 1'b0;
                        shreg      <= '0;
                        state      <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef TINY_ETH_PHY_RX_STATS_EN
    // Count clean and errored frame ends; both wrap naturally at 16 bits.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (rx_eof && !rx_err) frame_cnt <= frame_cnt + 16'd1;
            if (rx_err)            err_cnt   <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tiny_eth_phy_rx.sv
// Directed bench for tiny_eth_phy_rx: a DATA_W=4 and a DATA_W=8 instance
// share serial_in, each has its own serial_dv. Frames come from a vector
// table with hand-computed words; a negedge monitor compares every DUT
// event against an expected queue.
module tb_tiny_eth_phy_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       serial_in;
    logic       dv4, dv8;
    logic [3:0] d4;
    logic       v4, s4, e4, r4;
    logic [7:0] d8;
    logic       v8, s8, e8, r8;
`ifdef TINY_ETH_PHY_RX_STATS_EN
    logic [15:0] fc4, ec4, fc8, ec8;
`endif

    tiny_eth_phy_rx #(.DATA_W(4), .MIN_PRE_BITS(16)) dut4 (
        .rx_clk    (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .serial_dv (dv4),
        .rx_data   (d4),
        .rx_valid  (v4),
        .rx_sof    (s4),
        .rx_eof    (e4),
`ifdef TINY_ETH_PHY_RX_STATS_EN
        .rx_err    (r4),
        .frame_cnt (fc4),
        .err_cnt   (ec4)
`else
        .rx_err    (r4)
`endif
    );

    tiny_eth_phy_rx #(.DATA_W(8), .MIN_PRE_BITS(16)) dut8 (
        .rx_clk    (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .serial_dv (dv8),
        .rx_data   (d8),
        .rx_valid  (v8),
        .rx_sof    (s8),
        .rx_eof    (e8),
`ifdef TINY_ETH_PHY_RX_STATS_EN
        .rx_err    (r8),
        .frame_cnt (fc8),
        .err_cnt   (ec8)
`else
        .rx_err    (r8)
`endif
    );

    typedef struct {
        logic        sel8;
        logic [31:0] pre_pat;
        int          pre_len;
        logic [31:0] data;
        int          data_len;
        int          n_words;
        logic [31:0] words;
        logic        eof;
        logic        err;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    int sel    = 0;
    int good4  = 0;
    int bad4   = 0;
    logic [35:0] exp_q[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    task automatic check_event(input logic [35:0] ev);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_event: got %0h want none", ev);
        end else begin
            chk("event", ev, exp_q.pop_front());
        end
    endtask

    // Event code: [35:34] kind (1 word, 2 eof), [33] sof or err, [31:0] word.
    task automatic mon_step(input logic v, input logic s, input logic [31:0] d,
                            input logic e, input logic r);
        if (v) check_event({2'b01, s, 1'b0, d});
        if (e) check_event({2'b10, r, 1'b0, 32'd0});
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sel == 0) begin
                mon_step(v4, s4, {28'd0, d4}, e4, r4);
                if (v8 || e8) check_event({2'b11, 2'b00, 24'd0, d8});
            end else begin
                mon_step(v8, s8, {24'd0, d8}, e8, r8);
                if (v4 || e4) check_event({2'b11, 2'b00, 28'd0, d4});
            end
        end
    end

    task automatic drive_bit(input logic s, input logic dv);
        serial_in = s;
        if (sel == 0) dv4 = dv;
        else          dv8 = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] pre_pat, input int pre_len,
                              input logic [31:0] data, input int data_len);
        logic [7:0] sfd;
        sfd = 8'hD5;
        for (int i = 0; i < pre_len; i++)  drive_bit(pre_pat[i], 1'b1);
        for (int i = 0; i < 8; i++)        drive_bit(sfd[i], 1'b1);
        for (int i = 0; i < data_len; i++) drive_bit(data[i], 1'b1);
        for (int i = 0; i < 3; i++)        drive_bit(1'b0, 1'b0);
    endtask

    task automatic expect_frame(input logic sel8, input int n_words, input logic [31:0] words,
                                input logic eof, input logic err);
        int          w;
        logic [31:0] mask;
        w    = sel8 ? 8 : 4;
        mask = sel8 ? 32'hFF : 32'hF;
        for (int k = 0; k < n_words; k++)
            exp_q.push_back({2'b01, (k == 0), 1'b0, (words >> (w * k)) & mask});
        if (eof) exp_q.push_back({2'b10, err, 1'b0, 32'd0});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data4"}, {32'd0, d4}, 36'd0);
        chk({tag, "_strb4"}, {32'd0, v4, s4, e4, r4}, 36'd0);
        chk({tag, "_data8"}, {28'd0, d8}, 36'd0);
        chk({tag, "_strb8"}, {32'd0, v8, s8, e8, r8}, 36'd0);
    endtask

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b0, 32'h55555555, 16, 32'h3C,   8,  2, 32'h3C,   1'b1, 1'b0}; // basic C,3
        vt[1]  = '{1'b0, 32'h55555555,  8, 32'h1234, 16, 0, 32'h0,    1'b0, 1'b0}; // short preamble
        vt[2]  = '{1'b0, 32'h55555555, 16, 32'h2D,   6,  1, 32'hD,    1'b1, 1'b1}; // truncated
        vt[3]  = '{1'b0, 32'h55555555, 16, 32'hA5F0, 16, 4, 32'hA5F0, 1'b1, 1'b0}; // good after error
        vt[4]  = '{1'b0, 32'h55555555, 16, 32'h0,    0,  0, 32'h0,    1'b1, 1'b1}; // zero-word frame
        vt[5]  = '{1'b0, 32'h55555555, 15, 32'h0,    8,  0, 32'h0,    1'b0, 1'b0}; // one bit short
        vt[6]  = '{1'b0, 32'hFFFF0F00, 32, 32'h96,   8,  2, 32'h96,   1'b1, 1'b0}; // noisy preamble
        vt[7]  = '{1'b0, 32'h55555555, 24, 32'h5,    4,  1, 32'h5,    1'b1, 1'b0}; // long preamble, 1 word
        vt[8]  = '{1'b1, 32'h55555555, 16, 32'hA7,   8,  1, 32'hA7,   1'b1, 1'b0}; // DATA_W=8 single byte
        vt[9]  = '{1'b1, 32'h55555555, 16, 32'h1F2E, 16, 2, 32'h1F2E, 1'b1, 1'b0}; // DATA_W=8 two bytes
        vt[10] = '{1'b1, 32'h55555555, 16, 32'h3,    4,  0, 32'h0,    1'b1, 1'b1}; // DATA_W=8 partial

        // Clock/reset: reset held 3 cycles with toggling inputs.
        rst = 1'b1; serial_in = 1'b0; dv4 = 1'b0; dv8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            dv4       = 1'($urandom_range(0, 1));
            dv8       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk_outputs_zero("reset");
        dv4 = 1'b0; dv8 = 1'b0; serial_in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 11; i++) begin
            sel = vt[i].sel8 ? 1 : 0;
            expect_frame(vt[i].sel8, vt[i].n_words, vt[i].words, vt[i].eof, vt[i].err);
            if (!vt[i].sel8 && vt[i].eof) begin
                if (vt[i].err) bad4++;
                else           good4++;
            end
            send_frame(vt[i].pre_pat, vt[i].pre_len, vt[i].data, vt[i].data_len);
            chk($sformatf("drained_v%0d", i), 36'(exp_q.size()), 36'd0);
            exp_q.delete();
            if (vt[i].n_words > 0) begin
                if (vt[i].sel8)
                    chk($sformatf("hold8_v%0d", i), {28'd0, d8},
                        {4'd0, (vt[i].words >> (8 * (vt[i].n_words - 1))) & 32'hFF});
                else
                    chk($sformatf("hold4_v%0d", i), {32'd0, d4},
                        {4'd0, (vt[i].words >> (4 * (vt[i].n_words - 1))) & 32'hF});
            end
        end

`ifdef TINY_ETH_PHY_RX_STATS_EN
        chk("frame_cnt4", {20'd0, fc4}, 36'(good4));
        chk("err_cnt4",   {20'd0, ec4}, 36'(bad4));
        chk("frame_cnt8", {20'd0, fc8}, 36'd2);
        chk("err_cnt8",   {20'd0, ec8}, 36'd1);
        // Wrap: preload the counter at all-ones, one more good frame rolls it to 0.
        sel = 0;
        force dut4.frame_cnt = 16'hFFFF;
        #1;
        release dut4.frame_cnt;
        expect_frame(1'b0, 1, 32'h9, 1'b1, 1'b0);
        send_frame(32'h55555555, 16, 32'h9, 4);
        chk("drained_wrap", 36'(exp_q.size()), 36'd0);
        exp_q.delete();
        chk("frame_cnt_wrap", {20'd0, fc4}, 36'd0);
`endif

        // Asynchronous reset in the middle of DATA on the 4-bit instance.
        sel = 0;
        begin
            logic [7:0] sfd;
            sfd = 8'hD5;
            for (int i = 0; i < 16; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 1'b1);
            for (int i = 0; i < 8; i++)  drive_bit(sfd[i], 1'b1);
            drive_bit(1'b1, 1'b1);
            drive_bit(1'b1, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
`ifdef TINY_ETH_PHY_RX_STATS_EN
        chk("async_rst_fc4", {20'd0, fc4}, 36'd0);
`endif
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        // Carrier stays up after release: the FSM is back in HUNT, so no words or eof.
        for (int i = 0; i < 12; i++) drive_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  drive_bit(1'b0, 1'b0);
        chk("post_rst_quiet", 36'(exp_q.size()), 36'd0);
        chk("post_rst_data4", {32'd0, d4}, 36'd0);

        // A fresh frame locks and delivers after the reset.
        expect_frame(1'b0, 2, 32'hE1, 1'b1, 1'b0);
        send_frame(32'h55555555, 16, 32'hE1, 8);
        chk("drained_post_rst", 36'(exp_q.size()), 36'd0);
        exp_q.delete();
`ifdef TINY_ETH_PHY_RX_STATS_EN
        chk("post_rst_fc4", {20'd0, fc4}, 36'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tiny_eth_phy_rx.md
# tiny_eth_phy_rx

Parametrised serial receive front-end for the tiny_eth PHY and the successor to the fixed 4-bit serial-to-nibble path. It samples a single-bit line under a carrier/data-valid qualifier and hunts for an Ethernet preamble plus SFD. After lock it assembles LSB-first bits into DATA_W-bit words with valid, start-of-frame, end-of-frame and error strobes. It sits between the line sampler and the MAC receive logic in the rx_clk domain.

## Interface
- DATA_W, 4: output word width in bits; legal 1..32.
- MIN_PRE_BITS, 16: minimum preamble bits seen before the SFD for lock; legal 0..247.
- rx_clk  in  1  receive clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  line data bit, LSB-first bit order.
- serial_dv  in  1  carrier/data-valid qualifier for serial_in.
- rx_data  out  DATA_W  assembled word, held until the next word completes.
- rx_valid  out  1  one-cycle strobe: rx_data holds a new word.
- rx_sof  out  1  high together with rx_valid on the first word of a frame.
- rx_eof  out  1  one-cycle strobe: frame ended (serial_dv sampled low in DATA).
- rx_err  out  1  one-cycle strobe coincident with rx_eof when the frame ended on a partial word.

## Operation
- States: HUNT, DATA.
- HUNT, serial_dv=1:
  - Shift window: win <= {serial_in, win[7:1]}.
  - Increment hunt_cnt, 8 bits, saturating at 255.
  - If the post-shift window equals 8'hD5 and the post-increment hunt_cnt >= MIN_PRE_BITS+8, go to DATA with bit_cnt=0 and first_word=1.
- HUNT, serial_dv=0: clear win and hunt_cnt; stay in HUNT.
- DATA, serial_dv=1:
  - Shift: shreg <= {serial_in, shreg[DATA_W-1:1]}; increment bit_cnt.
  - When bit_cnt==DATA_W-1:
    - Set rx_data to the completed word and pulse rx_valid.
    - rx_sof <= first_word, then clear first_word.
    - Clear bit_cnt.
- DATA, serial_dv=0:
  - Pulse rx_eof.
  - Pulse rx_err if bit_cnt!=0 or first_word=1. A frame with zero whole words counts as an error.
  - Discard the partial word, clear all counters and the window, and go to HUNT.
- Preamble content is not checked bit-by-bit. Only the bit count and the final SFD match gate lock, so a noisy preamble still locks.
- The SFD must be 8'hD5, i.e. transmitted order 1,0,1,0,1,0,1,1. Preamble bytes are 8'h55.
- rx_data is never cleared except by rst. rx_valid, rx_sof, rx_eof and rx_err are registered pulses.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_sof=0, rx_eof=0, rx_err=0, state=HUNT, all counters 0.
- rst acts asynchronously mid-frame and forces the reset values immediately. The first edge after release samples normally.
- Lock: the edge that samples the last SFD bit moves to DATA. The next edge samples data bit 0.
- Word latency: the edge that samples bit DATA_W-1 updates rx_data and raises rx_valid. rx_valid drops on the next edge unless another word completes there. With DATA_W=1, rx_valid stays high continuously.
- EOF latency: the first edge that samples serial_dv=0 in DATA raises rx_eof (and rx_err if applicable) for exactly one cycle.
- No simultaneous rx_valid/rx_eof: serial_dv=0 never completes a word.
- A frame may restart immediately: HUNT samples on the cycle after rx_eof.

## Configuration
- TINY_ETH_PHY_RX_STATS_EN defined:
  - Adds output frame_cnt[15:0], incremented on every rx_eof without rx_err.
  - Adds output err_cnt[15:0], incremented on every rx_err.
  - Both counters wrap at 16'hFFFF→0 and reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package tiny_eth_pkg holds:
  - state enum (HUNT, DATA);
  - ETH_SFD = 8'hD5;
  - ETH_PREAMBLE = 8'h55;
  - HUNT_CNT_W = 8.
- Sub-module tiny_eth_sfd_det holds the 8-bit window, saturating hunt counter and lock compare. It has inputs rx_clk, rst, serial_in, serial_dv, clr and min_pre, and output lock_o. The top holds the FSM, word assembly and strobes.

## Test plan
- Reset: hold rst high for 3 cycles with toggling inputs -> all outputs 0. Assert rst mid-DATA -> outputs 0 immediately and no rx_valid afterwards until a new lock.
- DATA_W=4 frame: 16 bits 1010…, SFD 0xD5 LSB-first, byte 0x3C LSB-first, serial_dv low -> rx_valid twice:
  - first word 4'hC with rx_sof=1;
  - second word 4'h3 with rx_sof=0;
  - then rx_eof=1 with rx_err=0.
- Short preamble: 8 preamble bits + SFD + 16 data bits -> no rx_valid, no rx_eof. State remains HUNT until serial_dv drops.
- Truncated frame: valid lock, then serial_dv drops after 6 data bits -> one word 4'h? with rx_sof, then rx_eof and rx_err together. A following good frame locks and delivers correctly.
- DATA_W=8 instance: lock, then byte 0xA7 -> single rx_valid with rx_data=8'hA7 and rx_sof=1, then clean rx_eof.
- With TINY_ETH_PHY_RX_STATS_EN: 3 good frames + 1 truncated -> frame_cnt=3, err_cnt=1. Preload via 65536 good frames (or force) -> frame_cnt wraps to 0.
